p2s_stream: RTL and testbench

//  Parametrised parallel-to-serial converter, successor to the single-bit serializer in the lock datapath.

---
 rtl/p2s_pkg.sv | 21 ++
 rtl/p2s_hold_buf.sv | 36 +++
 rtl/p2s_stream.sv | 150 +++++++++++++++
 tb/tb_p2s_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// Shared types and elaboration helpers for the parallel-to-serial stream converter.
// The state enum names the three reachable (act_v, hold_v) combinations.
package p2s_pkg;

    typedef enum logic [1:0] {
        P2S_IDLE = 2'd0,
        P2S_BUSY = 2'd1,
        P2S_FULL = 2'd2
    } p2s_state_e;

    // Beats per word; a zero lane width is trapped by the top-level parameter check.
    function automatic int p2s_beats(int n, int w);
        return (w > 0) ? (n / w) : 1;
    endfunction

    // Counter width, never below one bit so single-beat words still get a valid vector.
    function automatic int p2s_cnt_w(int beats);
        return (beats <= 2) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/p2s_hold_buf.sv
// One-entry holding register that parks the next parallel word while the
// shift register is still draining the current one.
module p2s_hold_buf
    import p2s_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         take,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         valid
);

    logic [N-1:0] data_reg;
    logic         valid_reg;

    // Load wins over take; the top never asserts both together since par_ready is low while full.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= din;
            valid_reg <= 1'b1;
        end else if (take) begin
            valid_reg <= 1'b0;
        end
    end

    assign dout  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial converter: N-bit words in, N/W beats of W bits out, with a
// one-word holding buffer so back-to-back words stream without bubbles.
module p2s_stream
    import p2s_pkg::*;
#(
    parameter int N         = 8,
    parameter int W         = 1,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         par_valid,
    input  logic [N-1:0] par_data,
    output logic         par_ready,
    input  logic         ser_ready,
    output logic         ser_valid,
    output logic [W-1:0] ser_data,
    output logic         ser_last
);

    localparam int BEATS = p2s_beats(N, W);
    localparam int CW    = p2s_cnt_w(BEATS);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    generate
        if (N < 1 || W < 1 || W > N || ((W >= 1) ? (N % W) : 1) != 0) begin : g_param_check
            $error("p2s_stream: illegal parameters N=%0d W=%0d", N, W);
        end
    endgenerate

    logic [N-1:0]  shreg_reg, shreg_next, shreg_shifted;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          act_v_reg, act_v_next;
    logic [N-1:0]  hold_data;
    logic          hold_v;
    logic          hold_load, hold_take;
    logic          par_acc, ser_fire, last_beat;
    p2s_state_e    state;

    p2s_hold_buf #(
        .N (N)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load),
        .take  (hold_take),
        .din   (par_data),
        .dout  (hold_data),
        .valid (hold_v)
    );

    // Shift direction chosen at elaboration; a single-beat word never shifts.
    generate
        if (BEATS == 1) begin : g_single
            assign shreg_shifted = '0;
        end else if (LSB_FIRST) begin : g_lsb
            assign shreg_shifted = {{W{1'b0}}, shreg_reg[N-1:W]};
        end else begin : g_msb
            assign shreg_shifted = {shreg_reg[N-W-1:0], {W{1'b0}}};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lane
            if (LSB_FIRST) begin : g_lo
                assign ser_data[gi] = shreg_reg[gi];
            end else begin : g_hi
                assign ser_data[gi] = shreg_reg[N - W + gi];
            end
        end
    endgenerate

    // Ready depends only on registered state so no combinational path crosses the converter.
    assign par_ready = !hold_v;
    assign par_acc   = par_valid & par_ready;
    assign ser_valid = act_v_reg;
    assign last_beat = (cnt_reg == LAST_CNT);
    assign ser_last  = act_v_reg & last_beat;
    assign ser_fire  = act_v_reg & ser_ready;

    always_comb begin
        state = P2S_IDLE;
        if (hold_v) begin
            state = P2S_FULL;
        end else if (act_v_reg) begin
            state = P2S_BUSY;
        end
    end

    always_comb begin
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        act_v_next = act_v_reg;
        hold_load  = 1'b0;
        hold_take  = 1'b0;
        case (state)
            P2S_IDLE: begin
                if (par_acc) begin
                    shreg_next = par_data;
                    cnt_next   = '0;
                    act_v_next = 1'b1;
                end
            end
            P2S_BUSY: begin
                if (ser_fire && !last_beat) begin
                    shreg_next = shreg_shifted;
                    cnt_next   = cnt_reg + CW'(1);
                    hold_load  = par_acc;
                end else if (ser_fire) begin
                    // Last beat leaving: a word arriving now goes straight into the shifter.
                    if (par_acc) begin
                        shreg_next = par_data;
                        cnt_next   = '0;
                    end else begin
                        act_v_next = 1'b0;
                    end
                end else begin
                    hold_load = par_acc;
                end
            end
            P2S_FULL: begin
                if (ser_fire && !last_beat) begin
                    shreg_next = shreg_shifted;
                    cnt_next   = cnt_reg + CW'(1);
                end else if (ser_fire) begin
                    shreg_next = hold_data;
                    cnt_next   = '0;
                    hold_take  = 1'b1;
                end
            end
            default: begin
                act_v_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
            act_v_reg <= 1'b0;
        end else begin
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            act_v_reg <= act_v_next;
        end
    end

endmodule

// File: tb/tb_p2s_stream.sv
// Bench for p2s_stream: MSB-first and LSB-first 8/2 converters share stimulus,
// a 4/4 converter runs separately; a beat scoreboard checks every fired beat.
module tb_p2s_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pv, sr;
    logic [7:0] pd;
    logic       a_pr, a_sv, a_sl, b_pr, b_sv, b_sl;
    logic [1:0] a_sd, b_sd;
    logic       c_pv, c_sr, c_pr, c_sv, c_sl;
    logic [3:0] c_pd, c_sd;

    p2s_stream #(.N(8), .W(2), .LSB_FIRST(1'b0)) u_a (
        .clk(clk), .rst(rst), .par_valid(pv), .par_data(pd), .par_ready(a_pr),
        .ser_ready(sr), .ser_valid(a_sv), .ser_data(a_sd), .ser_last(a_sl));

    p2s_stream #(.N(8), .W(2), .LSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst(rst), .par_valid(pv), .par_data(pd), .par_ready(b_pr),
        .ser_ready(sr), .ser_valid(b_sv), .ser_data(b_sd), .ser_last(b_sl));

    p2s_stream #(.N(4), .W(4), .LSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst(rst), .par_valid(c_pv), .par_data(c_pd), .par_ready(c_pr),
        .ser_ready(c_sr), .ser_valid(c_sv), .ser_data(c_sd), .ser_last(c_sl));

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t qa[$], qb[$], qc[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic  a_acc;
    logic  a_stall_prev = 1'b0;
    logic [1:0] a_sd_prev = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard work at the falling edge, then return just after the rising edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        a_acc = 1'b0;
        if (rst) begin
            qa.delete(); qb.delete(); qc.delete();
            a_stall_prev = 1'b0;
        end else begin
            if (a_stall_prev) begin
                chk("a_stall_valid", a_sv, 1);
                chk("a_stall_data", a_sd, a_sd_prev);
            end
            a_stall_prev = a_sv && !sr;
            a_sd_prev    = a_sd;
            if (a_sv && sr) begin
                chk("a_sb_nonempty", qa.size() != 0, 1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    chk("a_sb_data", a_sd, e.d);
                    chk("a_sb_last", a_sl, e.l);
                end
            end
            if (b_sv && sr) begin
                chk("b_sb_nonempty", qb.size() != 0, 1);
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    chk("b_sb_data", b_sd, e.d);
                    chk("b_sb_last", b_sl, e.l);
                end
            end
            if (c_sv && c_sr) begin
                chk("c_sb_nonempty", qc.size() != 0, 1);
                if (qc.size() != 0) begin
                    e = qc.pop_front();
                    chk("c_sb_data", c_sd, e.d);
                    chk("c_sb_last", c_sl, e.l);
                end
            end
            if (pv && a_pr) begin
                a_acc = 1'b1;
                for (int i = 0; i < 4; i++)
                    qa.push_back(beat_t'{d: 8'(pd[7-2*i -: 2]), l: (i == 3)});
            end
            if (pv && b_pr) begin
                for (int i = 0; i < 4; i++)
                    qb.push_back(beat_t'{d: 8'(pd[2*i +: 2]), l: (i == 3)});
            end
            if (c_pv && c_pr)
                qc.push_back(beat_t'{d: 8'(c_pd), l: 1'b1});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_msb [4];
        logic [1:0] exp_lsb [4];
        logic [7:0] words [3];
        int idx, vcount, first_v, last_v;
        logic saw_pr_low;

        rst = 1'b1; pv = 1'b0; pd = '0; sr = 1'b0;
        c_pv = 1'b0; c_pd = '0; c_sr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_a_valid", a_sv, 0);
        chk("rst_a_last", a_sl, 0);
        chk("rst_a_data", a_sd, 0);
        chk("rst_a_ready", a_pr, 1);
        chk("rst_c_ready", c_pr, 1);

        // Single word 8'hB4, both lane orders
        exp_msb = '{2'b10, 2'b11, 2'b01, 2'b00};
        exp_lsb = '{2'b00, 2'b01, 2'b11, 2'b10};
        sr = 1'b1; pv = 1'b1; pd = 8'hB4;
        tick();
        pv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", a_sv, 1);
            chk("t1_msb_data", a_sd, exp_msb[i]);
            chk("t1_msb_last", a_sl, (i == 3));
            chk("t2_lsb_data", b_sd, exp_lsb[i]);
            chk("t2_lsb_last", b_sl, (i == 3));
            tick();
        end
        chk("t1_idle_valid", a_sv, 0);

        // Three words back to back with everything held high
        words = '{8'h12, 8'h34, 8'h56};
        idx = 0; vcount = 0; first_v = -1; last_v = -1; saw_pr_low = 1'b0;
        pv = 1'b1; pd = words[0];
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (a_acc && idx < 3) begin
                idx++;
                if (idx == 3) pv = 1'b0;
                else pd = words[idx];
            end
            if (!a_pr) saw_pr_low = 1'b1;
            if (a_sv) begin
                vcount++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
        end
        chk("t3_words_taken", idx, 3);
        chk("t3_beat_count", vcount, 12);
        chk("t3_no_bubble", last_v - first_v + 1, 12);
        chk("t3_ready_low_seen", saw_pr_low, 1);

        // Stall on the second beat with another word arriving meanwhile
        pv = 1'b1; pd = 8'hB4;
        tick();
        pv = 1'b0;
        tick();
        sr = 1'b0; pv = 1'b1; pd = 8'h3C;
        tick();
        pv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_frozen_data", a_sd, 2'b11);
            chk("t4_frozen_last", a_sl, 0);
            chk("t4_held_ready", a_pr, 0);
            if (i < 2) tick();
        end
        sr = 1'b1;
        tick();
        chk("t4_resume_b3", a_sd, 2'b01);
        tick();
        chk("t4_resume_b4", a_sd, 2'b00);
        chk("t4_resume_last", a_sl, 1);
        tick();
        chk("t4_next_word_b1", a_sd, 2'b00);
        chk("t4_next_word_notlast", a_sl, 0);
        for (int i = 0; i < 4; i++) tick();

        // Reset mid-word while the holding buffer is occupied
        pv = 1'b1; pd = 8'hB4;
        tick();
        pd = 8'h77;
        tick();
        pv = 1'b0;
        chk("t5_full_ready", a_pr, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_valid", a_sv, 0);
        chk("t5_rst_ready", a_pr, 1);
        chk("t5_rst_data", a_sd, 0);
        chk("t5_rst_last", a_sl, 0);
        pv = 1'b1; pd = 8'hFF;
        tick();
        pv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_ff_data", a_sd, 2'b11);
            tick();
        end
        chk("t5_ff_done", a_sv, 0);

        // N = W = 4: every beat is last, one word per cycle
        c_sr = 1'b1; c_pv = 1'b1; c_pd = 4'hA;
        tick();
        c_pd = 4'h5;
        chk("t6_c_data_a", c_sd, 4'hA);
        chk("t6_c_last_a", c_sl, 1);
        chk("t6_c_ready_a", c_pr, 1);
        tick();
        c_pv = 1'b0;
        chk("t6_c_data_5", c_sd, 4'h5);
        chk("t6_c_last_5", c_sl, 1);
        chk("t6_c_valid_5", c_sv, 1);
        tick();
        chk("t6_c_done", c_sv, 0);

        // Random valid/ready soak on all three converters
        for (int cyc = 0; cyc < 400; cyc++) begin
            pv   = 1'($urandom_range(0, 1));
            pd   = 8'($urandom);
            sr   = ($urandom_range(0, 3) != 0);
            c_pv = 1'($urandom_range(0, 1));
            c_pd = 4'($urandom);
            c_sr = 1'($urandom_range(0, 1));
            tick();
        end
        pv = 1'b0; c_pv = 1'b0; sr = 1'b1; c_sr = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("soak_a_drained", qa.size(), 0);
        chk("soak_b_drained", qb.size(), 0);
        chk("soak_c_drained", qc.size(), 0);
        chk("soak_a_idle", a_sv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
